// File: rtl/serv_rf_ram_bridge.sv
// Bridges the bit-serial two-read / two-write register file ports of a SERV
// core onto a width-bit synchronous RAM with one read and one write port.
module serv_rf_ram_bridge #(
   parameter int width    = 8,
   parameter int csr_regs = 4,
   localparam int rw = (csr_regs != 0) ? 6 : 5,
   localparam int aw = rw + 5 - $clog2(width)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_rreq,
   input  logic             i_wreq,
   output logic             o_ready,
   input  logic [rw-1:0]    i_rreg0,
   input  logic [rw-1:0]    i_rreg1,
   output logic             o_rdata0,
   output logic             o_rdata1,
   input  logic [rw-1:0]    i_wreg0,
   input  logic [rw-1:0]    i_wreg1,
   input  logic             i_wen0,
   input  logic             i_wen1,
   input  logic             i_wdata0,
   input  logic             i_wdata1,
   output logic [aw-1:0]    o_waddr,
   output logic [width-1:0] o_wdata,
   output logic             o_wen,
   output logic [aw-1:0]    o_raddr,
   output logic             o_ren,
   input  logic [width-1:0] i_rdata
);

   localparam int l2w = $clog2(width);
   localparam logic [l2w-1:0] ph_0    = '0;
   localparam logic [l2w-1:0] ph_1    = l2w'(1);
   localparam logic [l2w-1:0] ph_2    = l2w'(2);
   localparam logic [l2w-1:0] ph_last = '1;

   typedef enum logic [1:0] {
      SLOT_IDLE,
      SLOT_P0,
      SLOT_P1
   } wslot_t;

   // read side state
   logic [5:0]       rcnt_q, rcnt_d;
   logic             ract_q, ract_d;
   logic [width-1:0] rstage_q, rstage_d;
   logic [width-1:0] rsh0_q, rsh0_d;
   logic [width-1:0] rsh1_q, rsh1_d;

   // write side state
   logic [5:0]       wcnt_q, wcnt_d;
   logic             wact_q, wact_d;
   logic [width-2:0] wsh0_q, wsh0_d;
   logic [width-2:0] wsh1_q, wsh1_d;
   logic [width-1:0] wstg0_q, wstg0_d;
   logic [width-1:0] wstg1_q, wstg1_d;
   logic             wstg_en0_q, wstg_en0_d;
   logic             wstg_en1_q, wstg_en1_d;
   wslot_t           wslot_q, wslot_d;

   logic [l2w-1:0]   rphase;
   logic [l2w-1:0]   wphase;
   logic             rsel;
   logic             wbit;
   logic             wxfer;
   logic [rw-1:0]    rreg_sel;
   logic [rw-1:0]    wreg_sel;

   assign rphase   = rcnt_q[l2w-1:0];
   assign wphase   = wcnt_q[l2w-1:0];
   assign rsel     = (rphase == ph_1);
   assign wbit     = wact_q && (wcnt_q < 6'd32);
   assign wxfer    = wbit && (wphase == ph_last);
   assign rreg_sel = rsel ? i_rreg1 : i_rreg0;
   assign wreg_sel = (wslot_q == SLOT_P1) ? i_wreg1 : i_wreg0;

   // Read sequencer: two RAM reads per word, port 0 parked in staging until
   // port 1 returns so both operands start shifting out together.
   always_comb begin
      rcnt_d   = rcnt_q;
      ract_d   = ract_q;
      rstage_d = rstage_q;
      rsh0_d   = rsh0_q >> 1;
      rsh1_d   = rsh1_q >> 1;
      if (i_rreq) begin
         rcnt_d = '0;
         ract_d = 1'b1;
      end else if (ract_q) begin
         rcnt_d = rcnt_q + 6'd1;
         if (rcnt_q == 6'd34) ract_d = 1'b0;
      end
      if (ract_q && (rcnt_q < 6'd33) && (rphase == ph_1)) rstage_d = i_rdata;
      if (ract_q && (rcnt_q < 6'd34) && (rphase == ph_2)) begin
         rsh0_d = rstage_q;
         rsh1_d = i_rdata;
      end
   end

   assign o_ren    = ract_q && (rcnt_q < 6'd32) && ((rphase == ph_0) || (rphase == ph_1));
   assign o_ready  = ract_q && (rcnt_q == 6'd2);
   assign o_rdata0 = rsh0_q[0];
   assign o_rdata1 = rsh1_q[0];

   // Write sequencer: the word is completed by the bit arriving in the
   // transfer cycle, so only width-1 history bits are kept in the shifters.
   always_comb begin
      wcnt_d     = wcnt_q;
      wact_d     = wact_q;
      wsh0_d     = wsh0_q;
      wsh1_d     = wsh1_q;
      wstg0_d    = wstg0_q;
      wstg1_d    = wstg1_q;
      wstg_en0_d = wstg_en0_q;
      wstg_en1_d = wstg_en1_q;
      case (wslot_q)
         SLOT_P0: wslot_d = SLOT_P1;
         default: wslot_d = SLOT_IDLE;
      endcase
      if (i_wreq && !wact_q) begin
         wcnt_d = '0;
         wact_d = 1'b1;
      end else if (wact_q) begin
         wcnt_d = wcnt_q + 6'd1;
         if (wcnt_q == 6'd33) wact_d = 1'b0;
      end
      if (wbit) begin
         if (width > 2) begin
            wsh0_d = {i_wdata0, wsh0_q[width-2:1]};
            wsh1_d = {i_wdata1, wsh1_q[width-2:1]};
         end
      end
      if (wxfer) begin
         wstg0_d    = {i_wdata0, wsh0_q};
         wstg1_d    = {i_wdata1, wsh1_q};
         wstg_en0_d = i_wen0;
         wstg_en1_d = i_wen1;
         wslot_d    = SLOT_P0;
      end
   end

   assign o_wen   = (wslot_q == SLOT_P0) ? wstg_en0_q :
                    (wslot_q == SLOT_P1) ? wstg_en1_q : 1'b0;
   assign o_wdata = (wslot_q == SLOT_P1) ? wstg1_q : wstg0_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rcnt_q     <= '0;
         ract_q     <= 1'b0;
         rstage_q   <= '0;
         rsh0_q     <= '0;
         rsh1_q     <= '0;
         wcnt_q     <= '0;
         wact_q     <= 1'b0;
         wsh0_q     <= '0;
         wsh1_q     <= '0;
         wstg0_q    <= '0;
         wstg1_q    <= '0;
         wstg_en0_q <= 1'b0;
         wstg_en1_q <= 1'b0;
         wslot_q    <= SLOT_IDLE;
      end else begin
         rcnt_q     <= rcnt_d;
         ract_q     <= ract_d;
         rstage_q   <= rstage_d;
         rsh0_q     <= rsh0_d;
         rsh1_q     <= rsh1_d;
         wcnt_q     <= wcnt_d;
         wact_q     <= wact_d;
         wsh0_q     <= wsh0_d;
         wsh1_q     <= wsh1_d;
         wstg0_q    <= wstg0_d;
         wstg1_q    <= wstg1_d;
         wstg_en0_q <= wstg_en0_d;
         wstg_en1_q <= wstg_en1_d;
         wslot_q    <= wslot_d;
      end
   end

   // A 32-bit RAM holds a whole register per word, so there is no word index.
   if (l2w < 5) begin : g_idx
      localparam int iw = 5 - l2w;
      logic [iw-1:0] widx_q, widx_d;

      always_comb begin
         widx_d = widx_q;
         if (wxfer) widx_d = wcnt_q[4:l2w];
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) widx_q <= '0;
         else       widx_q <= widx_d;
      end

      assign o_raddr = {rreg_sel, rcnt_q[4:l2w]};
      assign o_waddr = {wreg_sel, widx_q};
   end else begin : g_noidx
      assign o_raddr = rreg_sel;
      assign o_waddr = wreg_sel;
   end

endmodule
